div_32bit_seq: RTL and testbench
================================

Name: div_32bit_seq

Overview:
Sequential signed/unsigned integer divider. It is the inverse-operation companion to the combinational multiplier in the CPU ALU datapath.
- Accepts a dividend and divisor on a start pulse.
- Runs one non-restoring iteration per clock.
- Returns quotient in LO and remainder in HI, packed as a 64-bit result matching the multiplier's product width.
- The control unit stalls on busy and latches the result into HI/LO on done.

Parameters:
WIDTH, 32, operand width in bits; iteration count equals WIDTH.
SIGNED, 1, 1 = two's-complement division, 0 = unsigned division.

Ports:
clk  input  1  rising-edge clock
clr  input  1  asynchronous active-high reset
start  input  1  one-cycle request; sampled only in IDLE
a  input  WIDTH  dividend
b  input  WIDTH  divisor
busy  output  1  high from the edge after start is accepted until done
done  output  1  one-cycle pulse; result is valid from this cycle onward
div_by_zero  output  1  set together with done when b==0; cleared on next accepted start
q  output  64  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: clr forces state IDLE and busy=0, done=0, div_by_zero=0, q=0, iteration counter=0. Reset during ITER or FIX aborts the operation with no done pulse.
- States: IDLE, ITER, FIX, DONE.
- IDLE: at the edge where start=1 (edge E0):
  - Capture |a|, |b| (or raw a, b if SIGNED=0) and the sign of a and of a^b.
  - Clear the partial remainder and counter; clear div_by_zero.
  - If b==0, go to DONE. Otherwise go to ITER.
- ITER: edges E1..E_WIDTH.
  - Shift {R,Q} left 1.
  - If R is non-negative, R = R − B; else R = R + B.
  - Set the new Q LSB = ~R sign.
  - Increment the counter. After WIDTH iterations, go to FIX.
  - R is WIDTH+1 bits wide to hold the sign.
- FIX: edge E_WIDTH+1.
  - If R is negative, R = R + B.
  - Quotient is negated if the signs differ (SIGNED=1).
  - Remainder takes the sign of the dividend (truncating division, C semantics).
  - Register q, assert done=1 and busy=0, go to IDLE.
  - Latency is WIDTH+1 clocks from start to done (33 for the default).
- DONE (divide by zero only), edge E1: q = {a, all-ones}, i.e. remainder = dividend and quotient = 0xFFFFFFFF; div_by_zero=1, done=1, go to IDLE. Latency is 1 clock.
- done is high for exactly one cycle.
- q holds its value until the next completion or reset.
- busy is high in ITER and FIX; low in IDLE and DONE.
- start while busy: ignored; the operation in flight is unaffected.
- start in the same cycle done is high: accepted, because the FSM is already in IDLE. The new operation starts; q keeps the old result until the new done.
- Operands are sampled only at E0. Later changes on a and b have no effect.
- Overflow case SIGNED=1, a=0x80000000, b=0xFFFFFFFF: quotient 0x80000000, remainder 0, no flag.
- SIGNED=0: no magnitude or sign correction; full unsigned range.

Test Plan:
- SIGNED=1, a=100, b=7, start pulse → done exactly 33 cycles later, q=0x00000002_0000000E, busy high for cycles 1..32 and 33.
- a=-100 (0xFFFFFF9C), b=7 → quotient 0xFFFFFFF2 (-14), remainder 0xFFFFFFFE (-2); a=100, b=-7 → quotient 0xFFFFFFF2, remainder 0x00000002.
- a=0x12345678, b=0 → done after 1 cycle, div_by_zero=1, q=0x12345678_FFFFFFFF; next valid start clears div_by_zero.
- a=0x80000000, b=0xFFFFFFFF → q=0x00000000_80000000. With SIGNED=0, a=0xFFFFFFFF, b=2 → q=0x00000001_7FFFFFFF.
- start pulsed again at cycle 10 with different operands → ignored; result matches the first operands. Back-to-back start on the done cycle → second result 33 cycles later.
- clr asserted asynchronously mid-ITER (cycle 15) → busy, done, q and div_by_zero immediately 0, no done pulse. A new start after clr release produces a correct result.

Source files
------------

// File: rtl/div_32bit_seq_if.sv
// Handshake and result bundle between the ALU control unit and the sequential divider.
interface div_32bit_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic               start;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic               div_by_zero;
    logic [2*WIDTH-1:0] q;

    modport master (
        output start, a, b,
        input  busy, done, div_by_zero, q
    );

    modport slave (
        input  start, a, b,
        output busy, done, div_by_zero, q
    );
endinterface

// File: rtl/div_32bit_seq.sv
// Sequential non-restoring divider, one quotient bit per clock.
// Result is {remainder, quotient}, truncating (C-style) when SIGNED=1.
module div_32bit_seq #(
    parameter int unsigned WIDTH  = 32,
    parameter bit          SIGNED = 1'b1
) (
    input logic            clk,
    input logic            clr,
    div_32bit_seq_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StIter, StFix, StDone} state_e;

    state_e             state_q;
    logic [WIDTH:0]     rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   dvs_q;
    logic               neg_rem_q;
    logic               neg_quo_q;
    logic [CntW-1:0]    cnt_q;
    logic               busy_q;
    logic               done_q;
    logic               dbz_q;
    logic [2*WIDTH-1:0] res_q;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     rem_step;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   rem_out;
    logic [WIDTH-1:0]   quo_out;

    always_comb begin
        a_neg     = SIGNED && bus.a[WIDTH-1];
        b_neg     = SIGNED && bus.b[WIDTH-1];
        a_mag     = a_neg ? -bus.a : bus.a;
        b_mag     = b_neg ? -bus.b : bus.b;
        // R wraps modulo 2^(WIDTH+1); the step result always fits, so the sign bit stays exact.
        rem_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        rem_step  = rem_q[WIDTH] ? rem_shift + {1'b0, dvs_q} : rem_shift - {1'b0, dvs_q};
        rem_fix   = rem_q[WIDTH] ? rem_q[WIDTH-1:0] + dvs_q : rem_q[WIDTH-1:0];
        rem_out   = neg_rem_q ? -rem_fix : rem_fix;
        quo_out   = neg_quo_q ? -quo_q : quo_q;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= StIdle;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_rem_q <= 1'b0;
            neg_quo_q <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            res_q     <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        rem_q     <= '0;
                        cnt_q     <= '0;
                        dbz_q     <= 1'b0;
                        neg_rem_q <= a_neg;
                        neg_quo_q <= a_neg ^ b_neg;
                        dvs_q     <= b_mag;
                        if (bus.b == '0) begin
                            // Raw dividend is parked in the quotient register for the zero case.
                            quo_q   <= bus.a;
                            state_q <= StDone;
                        end else begin
                            quo_q   <= a_mag;
                            busy_q  <= 1'b1;
                            state_q <= StIter;
                        end
                    end
                end
                StIter: begin
                    rem_q <= rem_step;
                    quo_q <= {quo_q[WIDTH-2:0], ~rem_step[WIDTH]};
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    res_q   <= {rem_out, quo_out};
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                StDone: begin
                    res_q   <= {quo_q, {WIDTH{1'b1}}};
                    dbz_q   <= 1'b1;
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.q           = res_q;
endmodule

// File: tb/tb_div_32bit_seq.sv
// Bench for div_32bit_seq: signed and unsigned instances driven in lockstep,
// checked against hand-computed vectors and a plain-arithmetic reference.
module tb_div_32bit_seq;
    logic clk;
    logic clr;
    int   checks;
    int   failures;
    logic [63:0] prev_s;
    logic [63:0] prev_u;

    div_32bit_seq_if #(.WIDTH(32)) s_if ();
    div_32bit_seq_if #(.WIDTH(32)) u_if ();

    div_32bit_seq #(.WIDTH(32), .SIGNED(1'b1)) dut_s (.clk(clk), .clr(clr), .bus(s_if));
    div_32bit_seq #(.WIDTH(32), .SIGNED(1'b0)) dut_u (.clk(clk), .clr(clr), .bus(u_if));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] qs;
        logic [63:0] qu;
        bit          dbz;
    } vec_t;

    vec_t tbl[8];

    // Returns {div_by_zero, remainder, quotient}; 64-bit math covers the -2^31 / -1 case.
    function automatic logic [64:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input bit sgn);
        longint sa;
        longint sb;
        longint qq;
        longint rr;
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        qq = sa / sb;
        rr = sa % sb;
        return {1'b0, rr[31:0], qq[31:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [31:0] av, input logic [31:0] bv);
        s_if.start = st;
        s_if.a     = av;
        s_if.b     = bv;
        u_if.start = st;
        u_if.a     = av;
        u_if.b     = bv;
    endtask

    // Called at a negedge. Operands are scrambled after acceptance to prove they are sampled once.
    task automatic run_op(input string name, input logic [31:0] av, input logic [31:0] bv,
                          input logic [63:0] es, input logic [63:0] eu, input bit edbz,
                          input bit launch, input int inject_at, input bit chain,
                          input logic [31:0] ca, input logic [31:0] cb);
        int          lat_s;
        int          lat_u;
        int          busy_s;
        int          busy_u;
        logic        bd_s;
        logic        bd_u;
        logic [63:0] hq_s;
        logic [63:0] hq_u;
        logic [63:0] q_s;
        logic [63:0] q_u;
        logic        z_s;
        logic        z_u;
        lat_s  = -1;
        lat_u  = -1;
        busy_s = 0;
        busy_u = 0;
        bd_s   = 1'b0;
        bd_u   = 1'b0;
        hq_s   = prev_s;
        hq_u   = prev_u;
        q_s    = '0;
        q_u    = '0;
        z_s    = 1'b0;
        z_u    = 1'b0;
        if (launch) drive(1'b1, av, bv);
        for (int k = 1; k <= 45 && (lat_s < 0 || lat_u < 0); k++) begin
            @(negedge clk);
            if (lat_s < 0) begin
                if (s_if.done) begin
                    lat_s = k - 1;
                    bd_s  = s_if.busy;
                    q_s   = s_if.q;
                    z_s   = s_if.div_by_zero;
                end else begin
                    if (s_if.busy) busy_s++;
                    if (s_if.q !== prev_s) hq_s = s_if.q;
                end
            end
            if (lat_u < 0) begin
                if (u_if.done) begin
                    lat_u = k - 1;
                    bd_u  = u_if.busy;
                    q_u   = u_if.q;
                    z_u   = u_if.div_by_zero;
                end else begin
                    if (u_if.busy) busy_u++;
                    if (u_if.q !== prev_u) hq_u = u_if.q;
                end
            end
            if (chain && lat_s >= 0 && lat_u >= 0) drive(1'b1, ca, cb);
            else if (k == inject_at) drive(1'b1, 32'd5, 32'd0);
            else drive(1'b0, $urandom, $urandom);
        end
        check($sformatf("%s/s latency", name), 64'(lat_s), edbz ? 64'd1 : 64'd33);
        check($sformatf("%s/u latency", name), 64'(lat_u), edbz ? 64'd1 : 64'd33);
        check($sformatf("%s/s q", name), q_s, es);
        check($sformatf("%s/u q", name), q_u, eu);
        check($sformatf("%s/s div_by_zero", name), 64'(z_s), 64'(edbz));
        check($sformatf("%s/u div_by_zero", name), 64'(z_u), 64'(edbz));
        check($sformatf("%s/s busy cycles", name), 64'(busy_s), edbz ? 64'd0 : 64'd33);
        check($sformatf("%s/u busy cycles", name), 64'(busy_u), edbz ? 64'd0 : 64'd33);
        check($sformatf("%s busy at done", name), {62'd0, bd_s, bd_u}, 64'd0);
        check($sformatf("%s/s q held", name), hq_s, prev_s);
        check($sformatf("%s/u q held", name), hq_u, prev_u);
        prev_s = es;
        prev_u = eu;
        if (!chain) begin
            @(negedge clk);
            check($sformatf("%s done one cycle", name), {62'd0, s_if.done, u_if.done}, 64'd0);
            check($sformatf("%s/s q after done", name), s_if.q, es);
        end
    endtask

    initial begin
        logic [64:0] rs;
        logic [64:0] ru;
        logic [31:0] ra;
        logic [31:0] rb;
        bit          seen;
        checks   = 0;
        failures = 0;
        prev_s   = '0;
        prev_u   = '0;

        tbl[0] = '{32'd100,        32'd7,          64'h00000002_0000000E,
                   64'h00000002_0000000E, 1'b0};
        tbl[1] = '{32'hFFFFFF9C,   32'd7,          64'hFFFFFFFE_FFFFFFF2,
                   64'h00000002_24924916, 1'b0};
        tbl[2] = '{32'd100,        32'hFFFFFFF9,   64'h00000002_FFFFFFF2,
                   64'h00000064_00000000, 1'b0};
        tbl[3] = '{32'h12345678,   32'd0,          64'h12345678_FFFFFFFF,
                   64'h12345678_FFFFFFFF, 1'b1};
        tbl[4] = '{32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000,
                   64'h80000000_00000000, 1'b0};
        tbl[5] = '{32'hFFFFFFFF,   32'd2,          64'hFFFFFFFF_00000000,
                   64'h00000001_7FFFFFFF, 1'b0};
        tbl[6] = '{32'd0,          32'd5,          64'h00000000_00000000,
                   64'h00000000_00000000, 1'b0};
        tbl[7] = '{32'd7,          32'd7,          64'h00000000_00000001,
                   64'h00000000_00000001, 1'b0};

        clr = 1'b1;
        drive(1'b0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        check("reset/s flags", {61'd0, s_if.busy, s_if.done, s_if.div_by_zero}, 64'd0);
        check("reset/u flags", {61'd0, u_if.busy, u_if.done, u_if.div_by_zero}, 64'd0);
        check("reset/s q", s_if.q, 64'd0);
        clr = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].qs, tbl[i].qu,
                   tbl[i].dbz, 1'b1, 0, 1'b0, 32'd0, 32'd0);
        end

        // Stray start at cycle 10 would be a divide-by-zero if it were accepted.
        run_op("ignored start", 32'd100, 32'd7, 64'h00000002_0000000E,
               64'h00000002_0000000E, 1'b0, 1'b1, 10, 1'b0, 32'd0, 32'd0);

        // New start in the done cycle; the first result must stay visible until the second done.
        run_op("chain first", 32'd100, 32'd7, 64'h00000002_0000000E,
               64'h00000002_0000000E, 1'b0, 1'b1, 0, 1'b1, 32'hFFFFFF9C, 32'd7);
        run_op("chain second", 32'hFFFFFF9C, 32'd7, 64'hFFFFFFFE_FFFFFFF2,
               64'h00000002_24924916, 1'b0, 1'b0, 0, 1'b0, 32'd0, 32'd0);

        // Asynchronous clear mid-iteration.
        drive(1'b1, 32'd100, 32'd7);
        @(negedge clk);
        drive(1'b0, 32'd0, 32'd0);
        repeat (14) @(negedge clk);
        #2 clr = 1'b1;
        #1;
        check("clr/s flags", {61'd0, s_if.busy, s_if.done, s_if.div_by_zero}, 64'd0);
        check("clr/u flags", {61'd0, u_if.busy, u_if.done, u_if.div_by_zero}, 64'd0);
        check("clr/s q", s_if.q, 64'd0);
        check("clr/u q", u_if.q, 64'd0);
        @(negedge clk);
        clr = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (s_if.done || u_if.done || s_if.busy || u_if.busy) seen = 1'b1;
        end
        check("clr no done", 64'(seen), 64'd0);
        prev_s = '0;
        prev_u = '0;
        run_op("after clr", 32'd100, 32'd7, 64'h00000002_0000000E,
               64'h00000002_0000000E, 1'b0, 1'b1, 0, 1'b0, 32'd0, 32'd0);

        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 3))
                0:       ra = $urandom_range(0, 1000);
                1:       ra = -$urandom_range(0, 1000);
                2:       ra = 32'h80000000 | $urandom_range(0, 3);
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1, 2:    rb = $urandom_range(1, 15);
                3:       rb = -$urandom_range(1, 15);
                4:       rb = 32'hFFFFFFFF;
                default: rb = $urandom;
            endcase
            rs = ref_div(ra, rb, 1'b1);
            ru = ref_div(ra, rb, 1'b0);
            run_op($sformatf("rand%0d a=%h b=%h", i, ra, rb), ra, rb, rs[63:0], ru[63:0],
                   rs[64], 1'b1, 0, 1'b0, 32'd0, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
